aes_inv_cipher_seq: RTL and testbench
=====================================

Name: aes_inv_cipher_seq

Overview:
- Iterative AES inverse-cipher engine for the vector encryption CPU. It is the decrypt-direction counterpart of parallelALUs, which applies the forward round operations to a 128-bit state.
- Takes a 128-bit ciphertext state plus round keys from an external round-key store, and produces the plaintext state after NR+1 cycles.
- Processes one round per clock and uses a valid/ready output handshake toward the vector register writeback.

Parameters:
- NR, 10, number of AES rounds. Legal values are 10, 12 and 14; any other value raises an elaboration error.
- RKW, 4, width of the round-key index. Must satisfy 2**RKW > NR.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- din  in  128  ciphertext state, sampled with start.
- rk_idx  out  RKW  round-key index requested this cycle. Driven combinationally from FSM state and round counter.
- rk  in  128  round key for rk_idx. Combinational read; valid in the same cycle.
- busy  out  1  high while not in IDLE.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- dout  out  128  plaintext state.

Behaviour:
- State layout is row-major, identical to parallelALUs. Byte s(r,c) sits at bits [127-8*(4r+c) -: 8], so row 0 occupies [127:96]. The rk input uses the same layout.
- Reset (asynchronous, rst_n=0) puts the FSM in IDLE and clears the state register to 0. Outputs in reset: dout=0, out_valid=0, busy=0, rk_idx=0.
- FSM state IDLE:
  - rk_idx=NR.
  - If start=1: load din, go to INIT.
  - If start=0: hold.
- FSM state INIT:
  - rk_idx=NR; state <= state ^ rk.
  - Set round counter rnd <= NR-1; go to ROUND.
- FSM state ROUND:
  - rk_idx=rnd.
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk).
  - If rnd==1 go to FINAL, else rnd <= rnd-1.
- FSM state FINAL:
  - rk_idx=0.
  - state <= InvSubBytes(InvShiftRows(state)) ^ rk.
  - Go to DONE.
- FSM state DONE:
  - out_valid=1, dout=state.
  - If out_ready=1 go to IDLE on that edge; otherwise hold with dout stable.
- Latency: with start sampled at edge T, out_valid is first high after edge T+NR+1 (11 cycles for NR=10).
  - Back-to-back throughput is NR+3 cycles per block (a start can be accepted in the cycle after the handshake).
- busy=1 in INIT, ROUND, FINAL and DONE.
- start outside IDLE is ignored, with no side effects, including in the DONE-handshake cycle.
- dout shows the state register at all times. Consumers may only trust it while out_valid=1.
- InvShiftRows: row r rotates right by r byte positions, i.e. s'(r,c) = s(r,(c-r) mod 4).
- InvMixColumns, per column, in GF(2^8) mod x^8+x^4+x^3+x+1:
  - Row 0: 0e 0b 0d 09
  - Row 1: 09 0e 0b 0d
  - Row 2: 0d 09 0e 0b
  - Row 3: 0b 0d 09 0e
- Reset asserted mid-operation aborts immediately (asynchronously) to reset values. No partial result is ever flagged valid.
- rk must be stable only while it is being combinationally consumed in that cycle. The block never registers rk ahead of use.

Decomposition:
- Package aes_pkg holds:
  - typedef state_t (logic [127:0]) and byte_t.
  - FSM enum inv_state_e {IDLE, INIT, ROUND, FINAL, DONE}.
  - Functions gf_xtime, gf_mul, inv_shift_rows, inv_mix_columns.
  - Constant AES_POLY = 8'h1b.
- Sub-module aes_inv_sbox: a 256-entry combinational byte lookup. Instantiate it 16 times to form InvSubBytes.

Test Plan:
- FIPS-197 App. B vector, NR=10:
  - Stimulus: din=128'h3902dc1925dc116a8409850b1dfb9732; key store holds the expansion of key 2b7e151628aed2a6abf7158809cf4f3c in row-major layout; out_ready=1.
  - Required response: dout=128'h328831e0435a3137f6309807a88da234 with out_valid high exactly 11 cycles after start; rk_idx sequence 10,10,9,...,1,0.
- Round-trip against parallelALUs:
  - Stimulus: encrypt M=128'h1f22df409ef37a35cf74b61ca97bbc4f with a reference model, then decrypt the result with matching round keys.
  - Required response: dout equals the original M.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid rises.
  - Required response: out_valid and dout stay stable and busy=1; out_valid drops one cycle after out_ready=1.
- Ignored start:
  - Stimulus: pulse start with a different din in cycles 3 and 8 of an operation.
  - Required response: the result is unchanged and no second operation is launched.
- Reset mid-round:
  - Stimulus: drive rst_n=0 during ROUND at rnd=5.
  - Required response: dout=0, out_valid=0, busy=0 immediately with no clock edge; the next start then decrypts the App. B vector correctly.
- NR=14 instance:
  - Stimulus: FIPS-197 C.3 AES-256 vector.
  - Required response: correct plaintext with out_valid high exactly 15 cycles after start.

Source files
------------

// File: rtl/aes_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : aes_pkg
// Brief   : Shared types, GF(2^8) helpers and inverse round transforms for
//           the iterative AES inverse cipher (row-major 128-bit state).
// Revision: 1.0 - initial release
// ============================================================================
package aes_pkg;

    typedef logic [127:0] state_t;
    typedef logic [7:0]   byte_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        INIT  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } inv_state_e;

    localparam byte_t AES_POLY = 8'h1b;

    function automatic byte_t gf_xtime(input byte_t a);
        return {a[6:0], 1'b0} ^ (a[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic byte_t gf_mul(input byte_t a, input byte_t b);
        byte_t acc;
        byte_t x;
        acc = '0;
        x   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ x;
            x = gf_xtime(x);
        end
        return acc;
    endfunction

    // s(r,c) lives at bits [127-8*(4r+c) -: 8]; row r rotates right by r.
    function automatic state_t inv_shift_rows(input state_t s);
        state_t o;
        o = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                o[127-8*(4*r+c) -: 8] = s[127-8*(4*r+((c-r+4)%4)) -: 8];
            end
        end
        return o;
    endfunction

    // Circulant matrix: row r uses coefficient {0e,0b,0d,09}[(k-r) mod 4].
    function automatic state_t inv_mix_columns(input state_t s);
        state_t      o;
        byte_t       acc;
        logic [31:0] coefs;
        coefs = 32'h0e0b0d09;
        o     = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = '0;
                for (int k = 0; k < 4; k++) begin
                    acc = acc ^ gf_mul(s[127-8*(4*k+c) -: 8],
                                       coefs[31-8*((k-r+4)%4) -: 8]);
                end
                o[127-8*(4*r+c) -: 8] = acc;
            end
        end
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_sbox.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : aes_inv_sbox
// Brief   : Combinational AES inverse S-box, one byte in, one byte out.
// Revision: 1.0 - initial release
// ============================================================================
module aes_inv_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    // Entry 0 is the leftmost byte, so entry v sits at packed index 255-v.
    localparam logic [255:0][7:0] c_inv_sbox = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    assign o_byte = c_inv_sbox[~i_byte];

endmodule
`default_nettype wire

// File: rtl/aes_inv_cipher_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : aes_inv_cipher_seq
// Brief   : Iterative AES inverse cipher, one round per clock, round keys
//           fetched combinationally by index, valid/ready result handshake.
// Revision: 1.0 - initial release
// ============================================================================
module aes_inv_cipher_seq
    import aes_pkg::*;
#(
    parameter int NR  = 10,
    parameter int RKW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [127:0]   din,
    output logic [RKW-1:0] rk_idx,
    input  logic [127:0]   rk,
    output logic           busy,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [127:0]   dout
);

    if (!(NR == 10 || NR == 12 || NR == 14)) begin : g_bad_nr
        $error("aes_inv_cipher_seq: NR must be 10, 12 or 14");
    end
    if ((1 << RKW) <= NR) begin : g_bad_rkw
        $error("aes_inv_cipher_seq: RKW too narrow to index round key NR");
    end

    localparam logic [RKW-1:0] c_nr       = RKW'(NR);
    localparam logic [RKW-1:0] c_rnd_init = RKW'(NR - 1);
    localparam logic [RKW-1:0] c_one      = RKW'(1);

    inv_state_e     r_state;
    inv_state_e     w_state_nxt;
    state_t         r_data;
    state_t         w_data_nxt;
    logic [RKW-1:0] r_rnd;
    logic [RKW-1:0] w_rnd_nxt;
    logic [RKW-1:0] w_rk_idx;

    state_t w_isr;
    state_t w_isb;
    state_t w_final;
    state_t w_round;

    assign w_isr = inv_shift_rows(r_data);

    for (genvar gi = 0; gi < 16; gi++) begin : g_sbox
        aes_inv_sbox u_sbox (
            .i_byte (w_isr[8*gi +: 8]),
            .o_byte (w_isb[8*gi +: 8])
        );
    end

    assign w_final = w_isb ^ rk;
    assign w_round = inv_mix_columns(w_final);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_rnd   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_data  <= w_data_nxt;
            r_rnd   <= w_rnd_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_rnd_nxt   = r_rnd;
        w_rk_idx    = '0;
        case (r_state)
            IDLE: begin
                w_rk_idx = c_nr;
                if (start) begin
                    w_data_nxt  = din;
                    w_state_nxt = INIT;
                end
            end
            INIT: begin
                w_rk_idx    = c_nr;
                w_data_nxt  = r_data ^ rk;
                w_rnd_nxt   = c_rnd_init;
                w_state_nxt = ROUND;
            end
            ROUND: begin
                w_rk_idx   = r_rnd;
                w_data_nxt = w_round;
                if (r_rnd == c_one) begin
                    w_state_nxt = FINAL;
                end else begin
                    w_rnd_nxt = r_rnd - c_one;
                end
            end
            FINAL: begin
                w_rk_idx    = '0;
                w_data_nxt  = w_final;
                w_state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // IDLE requests key NR, but the index must read zero while held in reset.
    assign rk_idx    = rst_n ? w_rk_idx : '0;
    assign busy      = (r_state != IDLE);
    assign out_valid = (r_state == DONE);
    assign dout      = r_data;

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_cipher_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_aes_inv_cipher_seq
// Brief   : Self-checking bench: FIPS-197 vectors plus random round trips
//           through a forward-cipher reference model (NR=10 and NR=14).
// Revision: 1.0 - initial release
// ============================================================================
module tb_aes_inv_cipher_seq;

    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic         start10 = 1'b0, start14 = 1'b0;
    logic [127:0] din10 = '0, din14 = '0;
    logic [3:0]   rk_idx10, rk_idx14;
    logic [127:0] rk10, rk14;
    logic         busy10, busy14, ov10, ov14;
    logic         ordy10 = 1'b1, ordy14 = 1'b1;
    logic [127:0] dout10, dout14;

    logic [127:0] ks10 [0:15];
    logic [127:0] ks14 [0:15];
    logic [127:0] mk   [0:14];
    logic [7:0]   sb   [0:255];

    int  total = 0;
    int  bad   = 0;
    int  q_idx[$];
    time t_s;

    always #5 clk = ~clk;

    assign rk10 = ks10[rk_idx10];
    assign rk14 = ks14[rk_idx14];

    aes_inv_cipher_seq #(.NR(10), .RKW(4)) u_dut10 (
        .clk(clk), .rst_n(rst_n), .start(start10), .din(din10),
        .rk_idx(rk_idx10), .rk(rk10), .busy(busy10), .out_valid(ov10),
        .out_ready(ordy10), .dout(dout10)
    );

    aes_inv_cipher_seq #(.NR(14), .RKW(4)) u_dut14 (
        .clk(clk), .rst_n(rst_n), .start(start14), .din(din14),
        .rk_idx(rk_idx14), .rk(rk14), .busy(busy14), .out_valid(ov14),
        .out_ready(ordy14), .dout(dout14)
    );

    // ---------------- reference model (forward cipher) ----------------
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        logic [15:0] t;
        t = {b, b} << n;
        return t[15:8];
    endfunction

    function automatic logic [7:0] gbt(input logic [127:0] s, input int r, input int c);
        return s[127-8*(4*r+c) -: 8];
    endfunction

    function automatic logic [127:0] sbt(input logic [127:0] s, input int r, input int c,
                                         input logic [7:0] v);
        s[127-8*(4*r+c) -: 8] = v;
        return s;
    endfunction

    // FIPS byte sequence (column-major) to row-major state layout
    function automatic logic [127:0] seq2rm(input logic [127:0] x);
        logic [127:0] o;
        o = '0;
        for (int i = 0; i < 16; i++) o = sbt(o, i % 4, i / 4, x[127-8*i -: 8]);
        return o;
    endfunction

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
    endfunction

    task automatic expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0] w [0:59];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gm(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int rd = 0; rd <= 14; rd++) mk[rd] = '0;
        for (int rd = 0; rd <= nr; rd++)
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    mk[rd] = sbt(mk[rd], r, c, w[4*rd+c][31-8*r -: 8]);
    endtask

    function automatic logic [127:0] enc(input logic [127:0] pt, input int nr);
        logic [127:0] s, t, u;
        logic [7:0]   a [0:3];
        s = pt ^ mk[0];
        for (int rd = 1; rd <= nr; rd++) begin
            t = '0;
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    t = sbt(t, r, c, sb[gbt(s, r, (c + r) % 4)]);
            if (rd != nr) begin
                u = '0;
                for (int c = 0; c < 4; c++) begin
                    for (int k = 0; k < 4; k++) a[k] = gbt(t, k, c);
                    for (int r = 0; r < 4; r++)
                        u = sbt(u, r, c, gm(8'h02, a[r]) ^ gm(8'h03, a[(r+1)%4]) ^
                                         a[(r+2)%4] ^ a[(r+3)%4]);
                end
                t = u;
            end
            s = t ^ mk[rd];
        end
        return s;
    endfunction

    task automatic load_ks(input bit s14);
        for (int i = 0; i < 15; i++) begin
            if (s14) ks14[i] = mk[i]; else ks10[i] = mk[i];
        end
    endtask

    // ---------------- checking and DUT access ----------------
    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic drive(input bit s14, input logic st, input logic [127:0] d);
        if (s14) begin start14 = st; din14 = d; end
        else     begin start10 = st; din10 = d; end
    endtask

    function automatic logic rd_valid(input bit s14); return s14 ? ov14 : ov10; endfunction
    function automatic logic rd_busy(input bit s14);  return s14 ? busy14 : busy10; endfunction
    function automatic int   rd_idx(input bit s14);   return s14 ? int'(rk_idx14) : int'(rk_idx10); endfunction
    function automatic logic [127:0] rd_dout(input bit s14); return s14 ? dout14 : dout10; endfunction

    // Called at a falling edge with the DUT idle; returns at a falling edge.
    task automatic do_op(input bit s14, input logic [127:0] ct, input int hold,
                         input bit inject, output logic [127:0] pt, output int lat);
        int cyc;
        q_idx.delete();
        chk("idle_busy", rd_busy(s14), 0);
        t_s = $time;
        drive(s14, 1'b1, ct);
        q_idx.push_back(rd_idx(s14));
        @(negedge clk);
        drive(s14, 1'b0, ct);
        cyc = 0;
        while (!rd_valid(s14) && cyc < 40) begin
            q_idx.push_back(rd_idx(s14));
            @(negedge clk);
            cyc++;
            if (inject && (cyc == 3 || cyc == 8)) drive(s14, 1'b1, ~ct);
            else drive(s14, 1'b0, ct);
        end
        chk("valid_seen", rd_valid(s14), 1);
        lat = cyc;
        pt  = rd_dout(s14);
        if (hold > 0) begin
            for (int h = 0; h < hold; h++) begin
                @(negedge clk);
                chk("bp_valid", rd_valid(s14), 1);
                chk("bp_dout", rd_dout(s14), pt);
                chk("bp_busy", rd_busy(s14), 1);
            end
            if (s14) ordy14 = 1'b1; else ordy10 = 1'b1;
            @(negedge clk);
            chk("bp_drop", rd_valid(s14), 0);
        end else begin
            if (inject) drive(s14, 1'b1, ~ct);
            @(negedge clk);
            drive(s14, 1'b0, ct);
            chk("hs_drop", rd_valid(s14), 0);
            chk("hs_idle", rd_busy(s14), 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] ct, pt, exp_v, m;
        logic [255:0] key;
        logic [7:0]   inv;
        int           lat, cyc;
        time          t1;

        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end
        for (int i = 0; i < 16; i++) begin ks10[i] = '0; ks14[i] = '0; end

        // reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_dout10", dout10, 0);
        chk("rst_valid10", ov10, 0);
        chk("rst_busy10", busy10, 0);
        chk("rst_idx10", rk_idx10, 0);
        chk("rst_dout14", dout14, 0);
        chk("rst_idx14", rk_idx14, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_idx10", rk_idx10, 10);
        chk("idle_idx14", rk_idx14, 14);

        // FIPS-197 App. B
        expand({128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, 4, 10);
        load_ks(1'b0);
        ct    = 128'h3902dc1925dc116a8409850b1dfb9732;
        exp_v = 128'h328831e0435a3137f6309807a88da234;
        do_op(1'b0, ct, 0, 1'b0, pt, lat);
        t1 = t_s;
        chk("appB_pt", pt, exp_v);
        chk("appB_lat", lat, 11);
        chk("appB_idx_len", q_idx.size(), 12);
        for (int i = 0; i < q_idx.size(); i++)
            chk($sformatf("appB_idx%0d", i), q_idx[i], (i < 2) ? 10 : 11 - i);

        // round trip, issued back-to-back with the previous block
        m  = 128'h1f22df409ef37a35cf74b61ca97bbc4f;
        do_op(1'b0, enc(m, 10), 0, 1'b0, pt, lat);
        chk("rt_pt", pt, m);
        chk("throughput", t_s - t1, 130);

        // backpressure
        ordy10 = 1'b0;
        do_op(1'b0, ct, 5, 1'b0, pt, lat);
        chk("bp_pt", pt, exp_v);

        // start pulses during an operation and in the handshake cycle
        do_op(1'b0, ct, 0, 1'b1, pt, lat);
        chk("ign_pt", pt, exp_v);
        chk("ign_lat", lat, 11);

        // reset while in ROUND with rnd=5
        drive(1'b0, 1'b1, ct);
        @(negedge clk);
        drive(1'b0, 1'b0, ct);
        cyc = 0;
        while (rk_idx10 != 4'd5 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_rnd5", rk_idx10, 5);
        chk("rnd5_busy", busy10, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_dout", dout10, 0);
        chk("mid_rst_valid", ov10, 0);
        chk("mid_rst_busy", busy10, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(1'b0, ct, 0, 1'b0, pt, lat);
        chk("post_rst_pt", pt, exp_v);

        // FIPS-197 C.3, AES-256
        expand(256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 8, 14);
        load_ks(1'b1);
        do_op(1'b1, seq2rm(128'h8ea2b7ca516745bfeafc49904b496089), 0, 1'b0, pt, lat);
        chk("c3_pt", pt, seq2rm(128'h00112233445566778899aabbccddeeff));
        chk("c3_lat", lat, 15);
        chk("c3_idx2", q_idx[2], 13);

        // random round trips
        for (int n = 0; n < 4; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom, 128'h0};
            m   = {$urandom, $urandom, $urandom, $urandom};
            expand(key, 4, 10);
            load_ks(1'b0);
            do_op(1'b0, enc(m, 10), 0, 1'b0, pt, lat);
            chk($sformatf("rnd10_pt%0d", n), pt, m);
        end
        for (int n = 0; n < 2; n++) begin
            key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            m   = {$urandom, $urandom, $urandom, $urandom};
            expand(key, 8, 14);
            load_ks(1'b1);
            do_op(1'b1, enc(m, 14), 0, 1'b0, pt, lat);
            chk($sformatf("rnd14_pt%0d", n), pt, m);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
